// File: rtl/mac_crc_chk.sv
// mac_crc_chk: Ethernet FCS checker. Folds the valid bytes of every accepted
// beat into a reflected CRC-32 in one cycle. At end of frame it reports the
// final CRC, the byte count, the keep-error flag and a pass flag (the residue
// matches the good-FCS magic value, at least 4 bytes, and no keep error).
// Compile option: MAC_CRC_ERR_CNT_EN builds the saturating failed-frame
// counter behind o_err_cnt. Without it, o_err_cnt is tied to zero.
module mac_crc_chk #(
    parameter int N_BYTES = 8,
    parameter int W_LEN   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clk_en,
    input  logic                 i_valid,
    input  logic                 i_sof,
    input  logic                 i_eof,
    input  logic [N_BYTES-1:0]   i_keep,
    input  logic [N_BYTES*8-1:0] i_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [31:0]          o_crc,
    output logic                 o_crc_ok,
    output logic                 o_keep_err,
    output logic [W_LEN-1:0]     o_len,
    output logic [W_LEN-1:0]     o_err_cnt
);

    localparam logic [31:0]        CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]        CRC_POLY_R  = 32'hEDB8_8320;
    localparam logic [31:0]        CRC_RESIDUE = 32'h2144_DF1C;
    localparam logic [N_BYTES-1:0] KEEP_ALL    = {N_BYTES{1'b1}};
    localparam logic [N_BYTES-1:0] KEEP_NONE   = {N_BYTES{1'b0}};
    localparam logic [N_BYTES-1:0] KEEP_ONE    = {{(N_BYTES-1){1'b0}}, 1'b1};
    localparam logic [W_LEN-1:0]   LEN_ZERO    = {W_LEN{1'b0}};
    localparam logic [W_LEN-1:0]   LEN_MAX     = {W_LEN{1'b1}};
    localparam logic [W_LEN-1:0]   LEN_MIN     = W_LEN'(32'd4);
    localparam int                 CNT_W       = $clog2(N_BYTES + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    // One byte through the reflected CRC-32 (LSB of the byte enters first).
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, b};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY_R;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Keep is legal when full on inner beats, or a non-empty run of ones
    // starting at byte 0 on the last beat (x & (x+1) == 0 for such runs).
    function automatic logic keep_legal(input logic [N_BYTES-1:0] keep, input logic eof);
        logic [N_BYTES-1:0] kp1;
        kp1 = keep + KEEP_ONE;
        if (eof) begin
            return (keep != KEEP_NONE) && ((keep & kp1) == KEEP_NONE);
        end else begin
            return keep == KEEP_ALL;
        end
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        crc_q, crc_d;
    logic [W_LEN-1:0]   len_q, len_d;
    logic               kerr_q, kerr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        crc_out_q, crc_out_d;
    logic               ok_q, ok_d;
    logic               kerr_out_q, kerr_out_d;
    logic [W_LEN-1:0]   len_out_q, len_out_d;

    logic               accept_s;
    logic               keep_ok_s;
    logic [N_BYTES-1:0] keep_eff_s;
    logic [31:0]        crc_base_s, crc_next_s;
    logic [W_LEN-1:0]   len_base_s, len_next_s;
    logic [W_LEN:0]     len_sum_s;
    logic [CNT_W-1:0]   nbytes_s;
    logic               kerr_base_s, kerr_next_s, ok_next_s;

    // Beat datapath: CRC fold, saturating byte count and keep checking.
    always_comb begin
        accept_s  = i_clk_en && i_valid && (i_sof || (state_q == ST_FRAME));
        keep_ok_s = keep_legal(i_keep, i_eof);
        if (keep_ok_s) begin
            keep_eff_s = i_keep;
        end else begin
            keep_eff_s = KEEP_ALL;
        end
        if (i_sof) begin
            crc_base_s  = CRC_INIT;
            len_base_s  = LEN_ZERO;
            kerr_base_s = 1'b0;
        end else begin
            crc_base_s  = crc_q;
            len_base_s  = len_q;
            kerr_base_s = kerr_q;
        end
        crc_next_s = crc_base_s;
        nbytes_s   = {CNT_W{1'b0}};
        for (int k = 0; k < N_BYTES; k++) begin
            if (keep_eff_s[k]) begin
                crc_next_s = crc_byte(crc_next_s, i_data[8*k +: 8]);
                nbytes_s   = nbytes_s + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                crc_next_s = crc_next_s;
            end
        end
        len_sum_s = {1'b0, len_base_s} + (W_LEN+1)'(nbytes_s);
        if (len_sum_s[W_LEN]) begin
            len_next_s = LEN_MAX;
        end else begin
            len_next_s = len_sum_s[W_LEN-1:0];
        end
        kerr_next_s = kerr_base_s || !keep_ok_s;
        ok_next_s   = ((~crc_next_s) == CRC_RESIDUE) && (len_next_s >= LEN_MIN) && !kerr_next_s;
    end

    // Next-state logic: nothing moves on a disabled cycle; eof publishes results.
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        len_d      = len_q;
        kerr_d     = kerr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        crc_out_d  = crc_out_q;
        ok_d       = ok_q;
        kerr_out_d = kerr_out_q;
        len_out_d  = len_out_q;
        if (i_clk_en) begin
            done_d = 1'b0;
            if (accept_s) begin
                crc_d  = crc_next_s;
                len_d  = len_next_s;
                kerr_d = kerr_next_s;
                if (i_eof) begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    crc_out_d  = ~crc_next_s;
                    ok_d       = ok_next_s;
                    kerr_out_d = kerr_next_s;
                    len_out_d  = len_next_s;
                end else begin
                    state_d = ST_FRAME;
                    busy_d  = 1'b1;
                end
            end else begin
                state_d = state_q;
            end
        end else begin
            done_d = done_q;
        end
    end

    // Frame state machine and registered result outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            crc_q      <= CRC_INIT;
            len_q      <= LEN_ZERO;
            kerr_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crc_out_q  <= 32'h0000_0000;
            ok_q       <= 1'b0;
            kerr_out_q <= 1'b0;
            len_out_q  <= LEN_ZERO;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            kerr_q     <= kerr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crc_out_q  <= crc_out_d;
            ok_q       <= ok_d;
            kerr_out_q <= kerr_out_d;
            len_out_q  <= len_out_d;
        end
    end

`ifdef MAC_CRC_ERR_CNT_EN
    logic [W_LEN-1:0] err_cnt_q, err_cnt_d;

    // Failed-frame counter advances on the same edge that raises o_done.
    always_comb begin
        if (accept_s && i_eof && !ok_next_s && (err_cnt_q != LEN_MAX)) begin
            err_cnt_d = err_cnt_q + {{(W_LEN-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Failed-frame counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_cnt_q <= LEN_ZERO;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
`else
    assign o_err_cnt = {W_LEN{1'b0}};
`endif

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_crc      = crc_out_q;
    assign o_crc_ok   = ok_q;
    assign o_keep_err = kerr_out_q;
    assign o_len      = len_out_q;

endmodule
